// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single data-memory port (one 128-bit line per access,
//            28-bit block address) among the four dcache cores of the
//            cache-switching data path. The active cache (pref_id) has
//            priority. The other requesters are served round-robin. A
//            bounded-preference counter stops the active cache from starving
//            the others. A grant is held for the owner's whole transaction.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   req_read       in   [NUM_REQ]         per-requester read request
//   req_write      in   [NUM_REQ]         per-requester write request
//   req_address    in   [NUM_REQ*ADDR_W]  packed addresses, i at [i*ADDR_W +: ADDR_W]
//   req_writedata  in   [NUM_REQ*DATA_W]  packed write lines, same packing
//   req_busywait   out  [NUM_REQ]         per-requester stall
//   req_readdata   out  [DATA_W]          mem_readdata broadcast
//   pref_id        in   [2]               id of the active cache
//   mem_read       out                    memory read strobe
//   mem_write      out                    memory write strobe
//   mem_address    out  [ADDR_W]          memory block address
//   mem_writedata  out  [DATA_W]          memory write line
//   mem_readdata   in   [DATA_W]          memory read line
//   mem_busywait   in                     memory stall
//   grant          out  [NUM_REQ]         one-hot owner, zero when idle
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 128,
    parameter int PREF_MAX = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_busywait,
    output logic [DATA_W-1:0]         req_readdata,
    input  logic [1:0]                pref_id,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_writedata,
    input  logic [DATA_W-1:0]         mem_readdata,
    input  logic                      mem_busywait,
    output logic [NUM_REQ-1:0]        grant
);

    localparam int c_ID_W  = 2;
    localparam int c_CNT_W = $clog2(PREF_MAX + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [c_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [c_CNT_W-1:0]   pref_cnt_q, pref_cnt_d;

    logic [NUM_REQ-1:0]   w_requesting;
    logic [NUM_REQ-1:0]   w_pref_mask;
    logic                 w_pref_req;
    logic                 w_others_any;
    logic                 w_pref_sat;
    logic                 w_rr_found;
    logic [c_ID_W-1:0]    w_rr_winner;

    assign w_requesting = req_read | req_write;
    assign w_pref_req   = w_requesting[pref_id];
    assign w_others_any = |(w_requesting & ~w_pref_mask);
    assign w_pref_sat   = (pref_cnt_q >= c_CNT_W'(PREF_MAX));

    always_comb begin
        w_pref_mask          = '0;
        w_pref_mask[pref_id] = 1'b1;
    end

    // Round-robin scan starting just after the last round-robin winner.
    // The active cache is skipped once it has used up its preference budget,
    // so a waiting requester is guaranteed to get in.
    always_comb begin : p_rr_scan
        logic [c_ID_W-1:0] w_idx;
        w_idx       = '0;
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = c_ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!w_rr_found && w_requesting[w_idx] &&
                !(w_pref_sat && (w_idx == pref_id))) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= c_ID_W'(NUM_REQ - 1);
            pref_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            pref_cnt_q <= pref_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        pref_cnt_d = pref_cnt_q;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (|w_requesting) begin
                    if (w_pref_req && (!w_pref_sat || !w_others_any)) begin
                        state_d = S_OWNED;
                        grant_d = w_pref_mask;
                        // The budget only counts wins taken while someone
                        // else was kept waiting.
                        if (w_others_any) begin
                            pref_cnt_d = pref_cnt_q + c_CNT_W'(1);
                        end else begin
                            pref_cnt_d = '0;
                        end
                    end else if (w_rr_found) begin
                        state_d              = S_OWNED;
                        grant_d[w_rr_winner] = 1'b1;
                        rr_ptr_d             = w_rr_winner;
                        pref_cnt_d           = '0;
                    end
                end
            end
            S_OWNED: begin
                // Held while the owner keeps either strobe up, so a writeback
                // followed by a fetch stays under one grant.
                if (!(|(w_requesting & grant_q))) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Memory-side mux; grant_q is zero in IDLE so everything idles at 0.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                mem_write     = req_write[i];
                mem_read      = req_read[i] & ~req_write[i];
                mem_address   = req_address[i*ADDR_W +: ADDR_W];
                mem_writedata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_busywait
            assign req_busywait[gi] = grant_q[gi] ? mem_busywait : w_requesting[gi];
        end
    endgenerate

    assign req_readdata = mem_readdata;
    assign grant        = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: a table of per-cycle
//            vectors followed by hand-written multi-grant sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_N = 4;
    localparam int c_AW = 28;
    localparam int c_DW = 128;

    logic                  clock;
    logic                  reset;
    logic [c_N-1:0]        req_read;
    logic [c_N-1:0]        req_write;
    logic [c_N*c_AW-1:0]   req_address;
    logic [c_N*c_DW-1:0]   req_writedata;
    logic [c_N-1:0]        req_busywait;
    logic [c_DW-1:0]       req_readdata;
    logic [1:0]            pref_id;
    logic                  mem_read;
    logic                  mem_write;
    logic [c_AW-1:0]       mem_address;
    logic [c_DW-1:0]       mem_writedata;
    logic [c_DW-1:0]       mem_readdata;
    logic                  mem_busywait;
    logic [c_N-1:0]        grant;

    mem_port_arbiter #(
        .NUM_REQ (c_N),
        .ADDR_W  (c_AW),
        .DATA_W  (c_DW),
        .PREF_MAX(4)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_writedata(req_writedata),
        .req_busywait (req_busywait),
        .req_readdata (req_readdata),
        .pref_id      (pref_id),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .grant        (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] rd;
        logic [3:0] wr;
        logic [1:0] pref;
        logic       mb;
        logic [3:0] gnt;
        logic       mrd;
        logic       mwr;
        logic [3:0] bw;
    } vec_t;

    localparam int c_ROWS = 23;
    vec_t            tbl [c_ROWS];
    logic [c_AW-1:0] addr_of [c_N];
    logic [c_DW-1:0] wdata_of [c_N];
    logic [3:0]      exp_seq [8];
    int              n_checks;
    int              n_fail;

    localparam logic [c_DW-1:0] c_RDATA = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

    function automatic vec_t mk(input logic rst, input logic [3:0] rd, input logic [3:0] wr,
                                input logic [1:0] pref, input logic mb, input logic [3:0] gnt,
                                input logic mrd, input logic mwr, input logic [3:0] bw);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.pref = pref; v.mb = mb;
        v.gnt = gnt; v.mrd = mrd; v.mwr = mwr; v.bw = bw;
        return v;
    endfunction

    function automatic logic [c_AW-1:0] exp_addr(input logic [3:0] g);
        logic [c_AW-1:0] a;
        a = '0;
        for (int i = 0; i < c_N; i++) if (g[i]) a = addr_of[i];
        return a;
    endfunction

    function automatic logic [c_DW-1:0] exp_wdata(input logic [3:0] g);
        logic [c_DW-1:0] d;
        d = '0;
        for (int i = 0; i < c_N; i++) if (g[i]) d = wdata_of[i];
        return d;
    endfunction

    task automatic chk(input string name, input int idx, input logic [c_DW-1:0] act,
                       input logic [c_DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Requesters in rd hold their request until granted; each owner keeps it
    // for one cycle, then drops it. With reassert set it re-requests during
    // the dead cycle, except after the last expected grant, when every request
    // is dropped so the arbiter returns to IDLE.
    task automatic run_seq(input int n, input bit reassert);
        logic [3:0] dropped;
        for (int k = 0; k < n; k++) begin
            @(negedge clock); #1;
            chk("seq_grant", k, c_DW'(grant), c_DW'(exp_seq[k]));
            chk("seq_mem_read", k, c_DW'(mem_read), c_DW'(1'b1));
            chk("seq_wait_busy", k, c_DW'(req_busywait & req_read & ~grant),
                c_DW'(req_read & ~exp_seq[k]));
            dropped  = exp_seq[k];
            req_read = req_read & ~dropped;
            @(negedge clock); #1;
            chk("seq_dead_cycle", k, c_DW'(grant), c_DW'(4'b0000));
            if (reassert && (k < n - 1)) req_read = req_read | dropped;
            else if (k == n - 1)         req_read = 4'b0000;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < c_N; i++) begin
            addr_of[i]  = 28'h000_0010 + c_AW'(i) * 28'h100;
            wdata_of[i] = {4{32'hA5A5_0000 + 32'(i)}};
            req_address[i*c_AW +: c_AW]   = addr_of[i];
            req_writedata[i*c_DW +: c_DW] = wdata_of[i];
        end
        reset        = 1'b1;
        req_read     = '0;
        req_write    = '0;
        pref_id      = 2'd0;
        mem_busywait = 1'b0;
        mem_readdata = c_RDATA;

        //                rst  rd       wr       pref mb   gnt      mrd  mwr  bw
        tbl[0]  = mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // single read from requester 0 (active cache)
        tbl[1]  = mk(1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001);
        tbl[2]  = mk(1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
        tbl[3]  = mk(1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000);
        tbl[4]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000);
        tbl[5]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // requester 3 (active) write -> read under one grant, requester 0 waits
        tbl[6]  = mk(1'b0, 4'b0001, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1001);
        tbl[7]  = mk(1'b0, 4'b0001, 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b1001);
        tbl[8]  = mk(1'b0, 4'b1001, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b1001);
        tbl[9]  = mk(1'b0, 4'b1001, 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b0001);
        // read and write both set on the owner: write wins
        tbl[10] = mk(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b1, 4'b0001);
        tbl[11] = mk(1'b0, 4'b0001, 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0001);
        tbl[12] = mk(1'b0, 4'b0001, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001);
        tbl[13] = mk(1'b0, 4'b0001, 4'b0000, 2'd3, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
        // reset while owned with memory busy
        tbl[14] = mk(1'b1, 4'b0001, 4'b0000, 2'd3, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
        tbl[15] = mk(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // first post-reset round-robin grant goes to requester 0
        tbl[16] = mk(1'b0, 4'b0011, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011);
        tbl[17] = mk(1'b0, 4'b0011, 4'b0000, 2'd2, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0010);
        tbl[18] = mk(1'b0, 4'b0010, 4'b0000, 2'd2, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0010);
        tbl[19] = mk(1'b0, 4'b0010, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010);
        tbl[20] = mk(1'b0, 4'b0010, 4'b0000, 2'd2, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000);
        tbl[21] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000);
        tbl[22] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);

        repeat (2) @(posedge clock);

        for (int r = 0; r < c_ROWS; r++) begin
            @(negedge clock);
            reset        = tbl[r].rst;
            req_read     = tbl[r].rd;
            req_write    = tbl[r].wr;
            pref_id      = tbl[r].pref;
            mem_busywait = tbl[r].mb;
            #1;
            chk("grant",        r, c_DW'(grant),        c_DW'(tbl[r].gnt));
            chk("mem_read",     r, c_DW'(mem_read),     c_DW'(tbl[r].mrd));
            chk("mem_write",    r, c_DW'(mem_write),    c_DW'(tbl[r].mwr));
            chk("req_busywait", r, c_DW'(req_busywait), c_DW'(tbl[r].bw));
            chk("mem_address",  r, c_DW'(mem_address),  c_DW'(exp_addr(tbl[r].gnt)));
            chk("mem_writedata", r, mem_writedata,      exp_wdata(tbl[r].gnt));
            chk("req_readdata", r, req_readdata,        c_RDATA);
        end

        // Round-robin among 1,2,3 with the active cache (0) idle, from reset.
        @(negedge clock);
        reset     = 1'b1;
        req_read  = '0;
        req_write = '0;
        @(negedge clock);
        reset        = 1'b0;
        pref_id      = 2'd0;
        mem_busywait = 1'b0;
        req_read     = 4'b1110;
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
        run_seq(4, 1'b1);

        // Requester 2 alone, not active: moves the round-robin pointer to 2.
        req_read   = 4'b0100;
        exp_seq[0] = 4'b0100;
        run_seq(1, 1'b0);

        // Active cache 2 against three waiters: four preferred grants, then
        // round-robin hands one to requester 3, then preference resumes.
        pref_id  = 2'd2;
        req_read = 4'b1111;
        exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b0100; exp_seq[4] = 4'b1000; exp_seq[5] = 4'b0100;
        run_seq(6, 1'b1);

        @(negedge clock); #1;
        chk("final_idle", 0, c_DW'(grant), c_DW'(4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
